// File: rtl/regbus_tb_memory_pkg.sv
// Register-bus request/response payloads for the bench-side memory slave.
package regbus_tb_memory_pkg;

    localparam int unsigned AddrWidth = 48;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } rsp_t;

endpackage

// File: rtl/regbus_tb_memory.sv
// Word-addressed register-bus memory slave: one contiguous window, byte-strobe
// writes, one wait state per access, error response for bad accesses.
module regbus_tb_memory #(
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          NumWords  = 1024,
    parameter type                  req_t     = regbus_tb_memory_pkg::req_t,
    parameter type                  rsp_t     = regbus_tb_memory_pkg::rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i,
    output rsp_t rsp_o
);

    localparam int unsigned          B         = DataWidth / 8;
    localparam int unsigned          OFF       = $clog2(B);
    localparam int unsigned          IDX       = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] Span      = AddrWidth'(NumWords * B);
    localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(B - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    rsp_t                 rsp_q;
    rsp_t                 rsp_d;
    logic [DataWidth-1:0] mem [NumWords];

    logic [AddrWidth-1:0] off;
    logic                 in_range;
    logic                 aligned;
    logic                 good;
    logic [IDX-1:0]       index;
    logic                 wr_en;
    logic [DataWidth-1:0] wmerge;

    // Address decode against the single window.
    assign off      = req_i.addr - BaseAddr;
    assign in_range = (req_i.addr >= BaseAddr) && (off < Span);
    assign aligned  = (req_i.addr & AlignMask) == '0;
    assign good     = in_range && aligned;
    assign index    = off[OFF +: IDX];
    assign wr_en    = (state_q == IDLE) && req_i.valid && good && req_i.write;

    // State and response registers; response is fully registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next state: accept in IDLE, acknowledge for exactly one cycle in RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i.valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next response: captured at accept, cleared when leaving RESP.
    always_comb begin
        rsp_d = '0;
        if (state_q == IDLE && req_i.valid) begin
            rsp_d.ready = 1'b1;
            if (!good) begin
                rsp_d.error = 1'b1;
            end else if (!req_i.write) begin
                rsp_d.rdata = mem[index];
            end
        end
    end

    // Byte-lane merge of write data over the current word.
    always_comb begin
        wmerge = mem[index];
        for (int unsigned k = 0; k < B; k++) begin
            if (req_i.wstrb[k]) wmerge[8*k +: 8] = req_i.wdata[8*k +: 8];
        end
    end

    // Storage: cleared on reset, written only by good accepted writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '{default: '0};
        end else if (wr_en) begin
            mem[index] <= wmerge;
        end
    end

    assign rsp_o = rsp_q;

endmodule

// File: tb/tb_regbus_tb_memory.sv
// Directed bench for regbus_tb_memory with a transaction-level reference model.
module tb_regbus_tb_memory;

    import regbus_tb_memory_pkg::*;

    localparam logic [47:0] BASE  = 48'h0000_8000_0000;
    localparam int          WORDS = 1024;

    logic clk;
    logic rst_n;
    req_t req;
    rsp_t rsp;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    // Reference model state.
    logic [31:0] mm [WORDS];
    logic        exp_ready = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;
    logic        m_good;
    logic [9:0]  m_idx;

    regbus_tb_memory #(
        .AddrWidth (48),
        .DataWidth (32),
        .BaseAddr  (BASE),
        .NumWords  (WORDS),
        .req_t     (req_t),
        .rsp_t     (rsp_t)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .rsp_o  (rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a request seen while not acknowledging is executed and answered next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mm[i] = '0;
            exp_ready = 1'b0;
            exp_rdata = '0;
            exp_err   = 1'b0;
        end else if (exp_ready) begin
            exp_ready = 1'b0;
            exp_rdata = '0;
            exp_err   = 1'b0;
        end else if (req.valid) begin
            m_good = (req.addr >= BASE) && (req.addr - BASE < 48'(WORDS * 4))
                     && (req.addr % 4 == 0);
            m_idx  = 10'((req.addr - BASE) / 4);
            exp_ready = 1'b1;
            exp_rdata = '0;
            exp_err   = !m_good;
            if (m_good && !req.write) exp_rdata = mm[m_idx];
            if (m_good && req.write) begin
                for (int k = 0; k < 4; k++)
                    if (req.wstrb[k]) mm[m_idx][8*k +: 8] = req.wdata[8*k +: 8];
            end
        end else begin
            exp_ready = 1'b0;
            exp_rdata = '0;
            exp_err   = 1'b0;
        end
    end

    // Per-cycle comparison of the response channel against the model.
    always @(negedge clk) begin
        if (check_en) begin
            total++;
            if (rsp.ready !== exp_ready || rsp.rdata !== exp_rdata || rsp.error !== exp_err) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got ready=%b rdata=%h error=%b want ready=%b rdata=%h error=%b",
                         $time, rsp.ready, rsp.rdata, rsp.error, exp_ready, exp_rdata, exp_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Issue one access at the next falling edge and hold it until ready is seen.
    task automatic access(input logic [47:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er);
        int lat;
        lat = 0;
        @(negedge clk);
        req.addr  = a;
        req.write = w;
        req.wdata = d;
        req.wstrb = s;
        req.valid = 1'b1;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp.ready && lat < 10);
        chk("latency", 32'(lat), 32'd1);
        rd = rsp.rdata;
        er = rsp.error;
    endtask

    task automatic idle();
        @(negedge clk);
        req = '0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        req   = '0;
        rst_n = 1'b0;
        @(posedge clk);
        check_en = 1'b1;

        // Reset then read.
        repeat (3) @(negedge clk);
        chk("reset_rsp", 32'(rsp), 32'd0);
        rst_n = 1'b1;
        access(BASE + 48'h10, 1'b0, 32'h0, 4'h0, rd, er);
        chk("rst_read_data", rd, 32'h0000_0000);
        chk("rst_read_err", 32'(er), 32'd0);
        idle();

        // Full write then read back.
        access(BASE + 48'h4, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er);
        chk("wr_data_zero", rd, 32'h0);
        idle();
        access(BASE + 48'h4, 1'b0, 32'h0, 4'h0, rd, er);
        chk("full_readback", rd, 32'hDEAD_BEEF);
        chk("full_readback_err", 32'(er), 32'd0);
        idle();

        // Byte-strobe merge.
        access(BASE + 48'h4, 1'b1, 32'h1122_3344, 4'h5, rd, er);
        idle();
        access(BASE + 48'h4, 1'b0, 32'h0, 4'h0, rd, er);
        chk("strobe_merge", rd, 32'hDE22_BE44);
        idle();

        // Zero-strobe write leaves the word alone.
        access(BASE + 48'h4, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, er);
        chk("zero_strb_err", 32'(er), 32'd0);
        idle();
        access(BASE + 48'h4, 1'b0, 32'h0, 4'h0, rd, er);
        chk("zero_strb_keep", rd, 32'hDE22_BE44);
        idle();

        // Error cases: misaligned, one past the end, below base.
        access(BASE + 48'h2, 1'b0, 32'h0, 4'h0, rd, er);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_data", rd, 32'h0);
        idle();
        access(BASE + 48'(WORDS * 4), 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_data", rd, 32'h0);
        idle();
        access(BASE - 48'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("below_err", 32'(er), 32'd1);
        idle();
        access(BASE, 1'b0, 32'h0, 4'h0, rd, er);
        chk("word0_unchanged", rd, 32'h0);
        idle();
        access(BASE + 48'((WORDS - 1) * 4), 1'b0, 32'h0, 4'h0, rd, er);
        chk("last_unchanged", rd, 32'h0);
        chk("last_read_err", 32'(er), 32'd0);
        idle();

        // Back-to-back alternating write/read with valid held high.
        access(BASE + 48'((WORDS - 1) * 4), 1'b1, 32'hCAFE_F00D, 4'hF, rd, er);
        chk("b2b_w0_err", 32'(er), 32'd0);
        access(BASE + 48'((WORDS - 1) * 4), 1'b0, 32'h0, 4'h0, rd, er);
        chk("b2b_last_word", rd, 32'hCAFE_F00D);
        chk("b2b_last_err", 32'(er), 32'd0);
        access(BASE + 48'h100, 1'b1, 32'h0F0F_1234, 4'hF, rd, er);
        access(BASE + 48'h100, 1'b0, 32'h0, 4'h0, rd, er);
        chk("b2b_mid_word", rd, 32'h0F0F_1234);
        idle();

        // Reset asserted while acknowledging a write.
        @(negedge clk);
        req.addr  = BASE + 48'h8;
        req.write = 1'b1;
        req.wdata = 32'hA5A5_A5A5;
        req.wstrb = 4'hF;
        req.valid = 1'b1;
        @(negedge clk);
        chk("mid_ready_high", 32'(rsp.ready), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_ready_drop", 32'(rsp.ready), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(BASE + 48'h8, 1'b0, 32'h0, 4'h0, rd, er);
        chk("mid_readback", rd, 32'h0);
        idle();
        access(BASE + 48'h4, 1'b0, 32'h0, 4'h0, rd, er);
        chk("reset_cleared", rd, 32'h0);
        idle();

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
